// File: rtl/shift_pkg.sv
// Shared encodings for the sequential right-shift unit.
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic SH_SRL = 1'b0;
    localparam logic SH_SRA = 1'b1;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter holding the remaining shift amount.
module down_counter #(
    parameter int size = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [size-1:0] load_val,
    input  logic            en,
    input  logic [size-1:0] dec,
    output logic [size-1:0] count,
    output logic            zero
);

    logic [size-1:0] count_q;
    logic [size-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q - dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle SRL/SRA unit: shifts STEP bits per cycle under a down-counter.
module seq_right_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    localparam int KW = $clog2(STEP + 1);

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   result_q;
    logic               fill_q;
    logic               out_valid_q;

    logic               accept;
    logic               cnt_load;
    logic               cnt_en;
    logic [SHAMT_W-1:0] cnt_val;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] dec;
    logic               rem_zero;
    logic [KW-1:0]      k;
    logic               last_step;
    logic [WIDTH-1:0]   shift_d;

    assign in_ready = (state_q == S_IDLE) && !clr;
    assign accept   = in_valid && in_ready;

    // k = min(STEP, rem); the shifter only ever moves up to STEP bits.
    assign k         = (32'(rem) < STEP) ? KW'(rem) : KW'(STEP);
    assign dec       = SHAMT_W'(k);
    assign last_step = rem_zero || (rem == dec);
    assign shift_d   = WIDTH'($signed({fill_q, data_q}) >>> k);

    assign cnt_load = clr || accept;
    assign cnt_val  = clr ? '0 : shamt;
    assign cnt_en   = (state_q == S_SHIFT);

    down_counter #(
        .size(SHAMT_W)
    ) u_rem (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(cnt_val),
        .en      (cnt_en),
        .dec     (dec),
        .count   (rem),
        .zero    (rem_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            fill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (clr) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        data_q <= x;
                        fill_q <= (arith == SH_SRA) & x[WIDTH-1];
                        if (shamt == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= x;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q <= shift_d;
                    if (last_step) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= shift_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter, STEP=1 and STEP=4 instances.
module tb_seq_right_shifter;

    logic        clk;
    logic        rst_n;
    logic        clr   [2];
    logic        iv    [2];
    logic        ir    [2];
    logic [31:0] xx    [2];
    logic [4:0]  sa    [2];
    logic        ar    [2];
    logic        ov    [2];
    logic        ordy  [2];
    logic [31:0] res   [2];
    logic        bsy   [2];

    int n_cmp;
    int n_err;

    seq_right_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .x(xx[0]), .shamt(sa[0]), .arith(ar[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .result(res[0]), .busy(bsy[0])
    );

    seq_right_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .x(xx[1]), .shamt(sa[1]), .arith(ar[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .result(res[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; inputs are scrambled right after accept.
    task automatic run(input int s, input logic [31:0] xv,
                       input logic [4:0] sh, input logic a,
                       input logic [31:0] er, input int el,
                       input int hold);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", 32'(ir[s]), 32'd1);
        iv[s] = 1'b1;
        xx[s] = xv;
        sa[s] = sh;
        ar[s] = a;
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
        xx[s] = 32'hDEAD_BEEF;
        sa[s] = 5'd9;
        ar[s] = ~a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[s] && lat < 200);
        chk("latency", 32'(lat), 32'(el));
        chk("result", res[s], er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ov[s]), 32'd1);
            chk("hold_result", res[s], er);
            chk("hold_in_ready", 32'(ir[s]), 32'd0);
        end
        ordy[s] = 1'b1;
        @(posedge clk);
        #1;
        ordy[s] = 1'b0;
        @(negedge clk);
        chk("valid_after_ack", 32'(ov[s]), 32'd0);
        chk("busy_after_ack", 32'(bsy[s]), 32'd0);
        chk("result_held", res[s], er);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clr[i]  = 1'b0;
            iv[i]   = 1'b0;
            xx[i]   = '0;
            sa[i]   = '0;
            ar[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(ov[0]), 32'd0);
        chk("rst_result", res[0], 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_busy4", 32'(bsy[1]), 32'd0);

        run(0, 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000, 5, 0);
        run(0, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32, 0);
        run(0, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32, 0);
        run(0, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 1, 3);

        run(1, 32'h8765_4321, 5'd7, 1'b1, 32'hFF0E_CA86, 3, 0);
        run(1, 32'hF000_0000, 5'd5, 1'b0, 32'h0780_0000, 3, 0);
        run(1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 9, 0);

        // Abort on the 5th SHIFT cycle.
        @(negedge clk);
        iv[0] = 1'b1;
        xx[0] = 32'hABCD_1234;
        sa[0] = 5'd20;
        ar[0] = 1'b0;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(bsy[0]), 32'd1);
        clr[0] = 1'b1;
        #1;
        chk("clr_in_ready", 32'(ir[0]), 32'd0);
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_valid", 32'(ov[0]), 32'd0);
        chk("abort_result", res[0], 32'd0);

        @(negedge clk);
        clr[0] = 1'b1;
        iv[0]  = 1'b1;
        xx[0]  = 32'h0000_00F0;
        sa[0]  = 5'd4;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        iv[0]  = 1'b0;
        chk("clr_req_busy", 32'(bsy[0]), 32'd0);
        repeat (6) @(negedge clk);
        chk("clr_req_valid", 32'(ov[0]), 32'd0);

        run(0, 32'h0000_0100, 5'd8, 1'b1, 32'h0000_0001, 9, 0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        iv[0] = 1'b1;
        xx[0] = 32'hFFFF_0000;
        sa[0] = 5'd20;
        ar[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(bsy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov[0]), 32'd0);
        chk("arst_busy", 32'(bsy[0]), 32'd0);
        chk("arst_result", res[0], 32'd0);
        #1;
        rst_n = 1'b1;

        run(0, 32'h0000_00FF, 5'd4, 1'b0, 32'h0000_000F, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
